mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-ported instruction/data memory between the fetch stage and the MEM stage of the MIPS pipeline.
- Sequences at most one data access and then one instruction fetch per pipeline advance.
- Drives a global `stall` that freezes every pipeline register, including IF and ID, while any access is outstanding.
- Adds a memory-wait watchdog that latches a fatal error.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MAX_WAIT`, 15, number of `m_req` cycles allowed without `m_ready` before a timeout. Must be ≥ 1.

Ports:
- `clk` input 1: clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch request, normally tied high while the core runs.
- `if_addr` input AW: fetch address (pc).
- `if_rdata` output DW: fetched instruction, held between fetches.
- `if_valid` output 1: one-cycle pulse; `if_rdata` holds the instruction for the latched `if_addr`.
- `d_req` input 1: data request (memwritem | memtoregm).
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input AW: data address (aluoutm).
- `d_wdata` input DW: store data.
- `d_rdata` output DW: load data, held between loads.
- `d_done` output 1: one-cycle pulse; the data access completed.
- `stall` output 1: freeze all pipeline stages.
- `m_req` output 1: memory request.
- `m_we` output 1: memory write enable.
- `m_addr` output AW: memory address.
- `m_wdata` output DW: memory write data.
- `m_rdata` input DW: memory read data, valid in the `m_ready` cycle.
- `m_ready` input 1: memory completes the transfer at this clock edge.
- `err` output 1: sticky timeout flag.

## Operation
- States: IDLE, DACC, IACC, DONE, ERR.
- Memory handshake:
  - `m_req`, `m_we`, `m_addr` and `m_wdata` are registered.
  - They stay stable from the edge that raises `m_req` until the edge where `m_req` and `m_ready` are both 1.
  - A transfer completes only at such an edge.
  - `m_ready` while `m_req` = 0 is ignored.
- IDLE:
  - `d_req` = 1 → DACC. Latch `m_addr` = `d_addr`, `m_we` = `d_we`, `m_wdata` = `d_wdata`, `m_req` = 1. Remember whether a fetch is pending (`if_req`).
  - Otherwise `if_req` = 1 → IACC. Latch `m_addr` = `if_addr`, `m_we` = 0, `m_req` = 1.
  - Otherwise stay in IDLE.
- DACC, on `m_ready`:
  - For a load, capture `d_rdata` = `m_rdata`.
  - If a fetch is pending → IACC with `m_addr` = `if_addr`, `m_we` = 0, `m_req` held at 1 (back-to-back).
  - Otherwise → DONE with `m_req` = 0.
- IACC, on `m_ready`: capture `if_rdata` = `m_rdata`, `m_req` = 0 → DONE.
- DONE:
  - `stall` = 0 for exactly this cycle, so the pipeline advances at its closing edge.
  - `if_valid` and `d_done` pulse during this cycle for whichever accesses ran in this group.
  - Next state is always IDLE.
- Watchdog:
  - The counter clears on every edge that starts a transfer and increments on each DACC/IACC cycle with `m_ready` = 0.
  - If `m_ready` is still 0 in the MAX_WAIT-th cycle of a transfer, go to ERR at that edge.
  - `m_ready` = 1 in that same cycle completes normally (ready wins).
- ERR: `m_req` = 0, `err` = 1, `stall` = 1. Left only by reset.
- `if_req`, `if_addr`, `d_req`, `d_we`, `d_addr` and `d_wdata` are sampled only in IDLE and at the DACC→IACC hand-off (`if_addr`). Changes at other times are ignored.
- `stall` is combinational:
  - 0 in DONE.
  - 0 in IDLE when `if_req` = `d_req` = 0.
  - 1 otherwise.
- `m_we` is 0 at all times `m_req` = 0.

## Timing
- Reset (async) values: state IDLE, `m_req`/`m_we`/`if_valid`/`d_done`/`err` = 0, `m_addr`/`m_wdata`/`if_rdata`/`d_rdata` = 0, counter = 0. `stall` then follows its rule.
- Reset mid-transfer drops `m_req` immediately. No completion pulse is produced.
- Zero-wait memory (`m_ready` = 1), measured as the number of cycles `stall` is held high plus the DONE cycle:
  - fetch only: 3 cycles (IDLE, IACC, DONE);
  - load or store plus fetch: 4 cycles;
  - store only with `if_req` = 0: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- `if_valid` and `d_done` are both high in the same DONE cycle when both accesses ran.
- `if_rdata` and `d_rdata` stay stable from capture until the next capture of the same kind.

## Test plan
- Fetch only:
  - Stimulus: `if_req` = 1, `if_addr` = 0x40, `d_req` = 0, `m_ready` = 1, `m_rdata` = 0x8C220004.
  - Response: `m_req` high 1 cycle with `m_addr` = 0x40, `m_we` = 0; `if_valid` pulses with `if_rdata` = 0x8C220004; `stall` low 1 in 3 cycles.
- Load plus fetch:
  - Stimulus: `d_req` = 1, `d_we` = 0, `d_addr` = 0x100, `if_addr` = 0x44; memory returns 0xDEADBEEF, then 0x00000000.
  - Response: `m_addr` sequence 0x100 then 0x44 with `m_req` continuous; `d_rdata` = 0xDEADBEEF; `d_done` and `if_valid` coincide in DONE; 4 cycles total.
- Store with 2 wait cycles:
  - Stimulus: `d_we` = 1, `d_addr` = 0x200, `d_wdata` = 0x12345678, `m_ready` low for 2 cycles.
  - Response: `m_we` = 1 and addr/data stable for 3 cycles; `d_rdata` unchanged; `stall` held until DONE.
- Timeout boundaries, `MAX_WAIT` = 15:
  - `m_ready` arrives in cycle 15 → normal completion, `err` = 0.
  - `m_ready` never arrives → ERR at the end of cycle 15; `err` = 1, `m_req` = 0, `stall` stuck at 1.
- Reset asserted in DACC:
  - Outputs clear immediately.
  - After release with `if_req` = 1, the block restarts with a fetch from the current `if_addr`.
- Request changes during stall: toggling `d_addr` and `if_addr` mid-access leaves `m_addr` unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Each pipeline advance runs an optional data access, then an optional fetch, then releases stall for one cycle.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DACC,
    S_IACC,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_m_req, w_m_req_next;
  logic          r_m_we, w_m_we_next;
  logic [AW-1:0] r_m_addr, w_m_addr_next;
  logic [DW-1:0] r_m_wdata, w_m_wdata_next;
  logic [DW-1:0] r_if_rdata, w_if_rdata_next;
  logic [DW-1:0] r_d_rdata, w_d_rdata_next;
  logic          r_if_pend, w_if_pend_next;
  logic          r_d_ran, w_d_ran_next;
  logic [CW-1:0] r_wait, w_wait_next;
  logic          w_timeout;

  // Ready in the last allowed cycle still completes; only a missing ready times out.
  assign w_timeout = (r_wait == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_pend  <= 1'b0;
      r_d_ran    <= 1'b0;
      r_wait     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_m_req    <= w_m_req_next;
      r_m_we     <= w_m_we_next;
      r_m_addr   <= w_m_addr_next;
      r_m_wdata  <= w_m_wdata_next;
      r_if_rdata <= w_if_rdata_next;
      r_d_rdata  <= w_d_rdata_next;
      r_if_pend  <= w_if_pend_next;
      r_d_ran    <= w_d_ran_next;
      r_wait     <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_m_req_next    = r_m_req;
    w_m_we_next     = r_m_we;
    w_m_addr_next   = r_m_addr;
    w_m_wdata_next  = r_m_wdata;
    w_if_rdata_next = r_if_rdata;
    w_d_rdata_next  = r_d_rdata;
    w_if_pend_next  = r_if_pend;
    w_d_ran_next    = r_d_ran;
    w_wait_next     = r_wait;

    case (r_state)
      S_IDLE: begin
        w_wait_next = '0;
        if (d_req) begin
          w_state_next   = S_DACC;
          w_m_req_next   = 1'b1;
          w_m_we_next    = d_we;
          w_m_addr_next  = d_addr;
          w_m_wdata_next = d_wdata;
          w_if_pend_next = if_req;
          w_d_ran_next   = 1'b1;
        end else if (if_req) begin
          w_state_next   = S_IACC;
          w_m_req_next   = 1'b1;
          w_m_we_next    = 1'b0;
          w_m_addr_next  = if_addr;
          w_if_pend_next = 1'b1;
          w_d_ran_next   = 1'b0;
        end
      end

      S_DACC: begin
        if (m_ready) begin
          if (!r_m_we) begin
            w_d_rdata_next = m_rdata;
          end
          w_wait_next = '0;
          if (r_if_pend) begin
            // Back-to-back: request stays high while the address switches to the fetch.
            w_state_next  = S_IACC;
            w_m_we_next   = 1'b0;
            w_m_addr_next = if_addr;
          end else begin
            w_state_next = S_DONE;
            w_m_req_next = 1'b0;
            w_m_we_next  = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_next = S_ERR;
          w_m_req_next = 1'b0;
          w_m_we_next  = 1'b0;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end

      S_IACC: begin
        if (m_ready) begin
          w_if_rdata_next = m_rdata;
          w_state_next    = S_DONE;
          w_m_req_next    = 1'b0;
          w_m_we_next     = 1'b0;
          w_wait_next     = '0;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
          w_m_req_next = 1'b0;
          w_m_we_next  = 1'b0;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      S_ERR: begin
        w_m_req_next = 1'b0;
        w_m_we_next  = 1'b0;
      end

      default: begin
        w_state_next = S_IDLE;
        w_m_req_next = 1'b0;
        w_m_we_next  = 1'b0;
      end
    endcase
  end

  // Pipeline advances only on the DONE cycle or when nothing is requested in IDLE.
  always_comb begin
    stall = 1'b1;
    if (r_state == S_DONE) begin
      stall = 1'b0;
    end else if ((r_state == S_IDLE) && !if_req && !d_req) begin
      stall = 1'b0;
    end
  end

  assign if_valid = (r_state == S_DONE) && r_if_pend;
  assign d_done   = (r_state == S_DONE) && r_d_ran;
  assign err      = (r_state == S_ERR);
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of access groups, bus scoreboard, and
// hand-written timeout and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    int          wait_d;
    int          wait_i;
    logic [31:0] rdata_d;
    logic [31:0] rdata_i;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  bus_t        mon_e;
  vec_t        vecs[7];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_d_rdata = 32'h0;
  logic [31:0] exp_if_rdata = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: held request must match the scoreboard head every cycle; pop on completion.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_req) begin
        if (bus_q.size() == 0) begin
          chk1("bus_unexpected_req", m_req, 1'b0);
        end else begin
          mon_e = bus_q[0];
          chk32("bus_addr", m_addr, mon_e.addr);
          chk1("bus_we", m_we, mon_e.we);
          if (mon_e.we) chk32("bus_wdata", m_wdata, mon_e.wdata);
          if (m_ready) void'(bus_q.pop_front());
        end
      end else begin
        chk1("bus_we_idle", m_we, 1'b0);
      end
    end
  end

  task automatic run_txn(input vec_t v, input int idx);
    int          n, phase, nph, cyc;
    int          wts[2];
    logic [31:0] rd[2];
    logic        done, xfer_done, was_req;
    nph = 0;
    wts[0] = 0; wts[1] = 0; rd[0] = 32'h0; rd[1] = 32'h0;
    if (v.d_req) begin
      wts[nph] = v.wait_d; rd[nph] = v.rdata_d; nph++;
      bus_q.push_back('{addr: v.d_addr, we: v.d_we, wdata: v.d_wdata});
    end
    if (v.if_req) begin
      wts[nph] = v.wait_i; rd[nph] = v.rdata_i; nph++;
      bus_q.push_back('{addr: v.if_addr, we: 1'b0, wdata: 32'h0});
    end
    if (v.d_req && !v.d_we) exp_d_rdata = v.rdata_d;
    if (v.if_req) exp_if_rdata = v.rdata_i;

    @(posedge clk); #1;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    if_req = v.if_req; if_addr = v.if_addr; m_ready = 1'b0;
    n = 1; phase = 0; cyc = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      xfer_done = m_req && m_ready;
      was_req = m_req;
      if (n > 1 && !stall) begin
        done = 1'b1;
        chk32("group_cycles", 32'(n), 32'(v.exp_cycles));
        chk1("if_valid_pulse", if_valid, v.if_req);
        chk1("d_done_pulse", d_done, v.d_req);
        chk32("d_rdata", d_rdata, exp_d_rdata);
        chk32("if_rdata", if_rdata, exp_if_rdata);
        chk1("err_clear", err, 1'b0);
        chk32("bus_q_empty", 32'(bus_q.size()), 32'd0);
      end
      @(posedge clk); #1;
      n++;
      if (xfer_done) begin
        phase++; cyc = 0;
      end else if (was_req) begin
        cyc++;
      end
      if (done) begin
        d_req = 1'b0; if_req = 1'b0; m_ready = 1'b0;
      end else begin
        m_ready = (phase < nph) && (cyc >= wts[phase]);
        m_rdata = m_ready ? rd[phase] : $urandom;
        // Inputs are not sampled once the group is running; scramble them.
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        if (v.if_req && phase == nph - 1) if_addr = $urandom;
      end
    end
    if (!done) chk1("group_timeout", done, 1'b1);
    @(negedge clk);
    chk1("idle_stall_low", stall, 1'b0);
    chk1("if_valid_one_cycle", if_valid, 1'b0);
    chk1("d_done_one_cycle", d_done, 1'b0);
    $display("txn %0d: d_req=%0b d_we=%0b if_req=%0b cycles=%0d d_rdata=%h if_rdata=%h",
             idx, v.d_req, v.d_we, v.if_req, n - 1, d_rdata, if_rdata);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h40, 0,  0,  32'h0,        32'h8C220004, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h44, 0,  0,  32'hDEADBEEF, 32'h00000000, 4};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0,  2,  0,  32'h0,        32'h0,        5};
    vecs[3] = '{1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 1'b1, 32'h48, 1,  3,  32'h0,        32'h27BDFFE8, 8};
    vecs[4] = '{1'b1, 1'b0, 32'h208, 32'h0,        1'b0, 32'h0,  0,  0,  32'h0BADC0DE, 32'h0,        3};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h4C, 0,  14, 32'h0,        32'hAFBF0010, 17};
    vecs[6] = '{1'b1, 1'b0, 32'h20C, 32'h0,        1'b1, 32'h50, 14, 14, 32'h55AA33CC, 32'h03E00008, 32};

    reset_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0; m_ready = 1'b0;
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk32("rst_m_wdata", m_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Watchdog: fetch that never gets ready must trap at the end of its 15th cycle.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h60; m_ready = 1'b0;
    bus_q.push_back('{addr: 32'h60, we: 1'b0, wdata: 32'h0});
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk1("wd_req_held", m_req, 1'b1);
      chk1("wd_no_err_yet", err, 1'b0);
      @(posedge clk);
    end
    #1;
    chk1("wd_err", err, 1'b1);
    chk1("wd_m_req_drop", m_req, 1'b0);
    chk1("wd_stall", stall, 1'b1);
    if_req = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("wd_err_sticky", err, 1'b1);
    chk1("wd_stall_sticky", stall, 1'b1);
    chk1("wd_m_req_low", m_req, 1'b0);
    $display("timeout: err=%0b stall=%0b m_req=%0b", err, stall, m_req);
    m_ready = 1'b0;
    reset_n = 1'b0; bus_q.delete(); exp_d_rdata = 32'h0; exp_if_rdata = 32'h0;
    #1;
    chk1("wd_reset_err", err, 1'b0);
    @(negedge clk); reset_n = 1'b1;

    // Reset during a data access: request drops at once, no completion pulse.
    run_txn(vecs[4], 7);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h80; m_ready = 1'b0;
    bus_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
    @(posedge clk); #1;
    chk1("dacc_m_req", m_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("midrst_m_req", m_req, 1'b0);
    chk32("midrst_m_addr", m_addr, 32'h0);
    chk32("midrst_d_rdata", d_rdata, 32'h0);
    chk1("midrst_d_done", d_done, 1'b0);
    chk1("midrst_if_valid", if_valid, 1'b0);
    chk1("midrst_stall", stall, 1'b1);
    $display("midreset: m_req=%0b stall=%0b", m_req, stall);
    bus_q.delete(); exp_d_rdata = 32'h0; exp_if_rdata = 32'h0;
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    run_txn('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h84, 0, 0, 32'h0, 32'h24420001, 3}, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
